// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared types and defaults for the frequency gate controller
package freq_pkg;

    localparam int FREQ_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        HOLD = 2'd2
    } freq_state_t;

endpackage

// File: rtl/freq_edge_detect.sv
// rtl/freq_edge_detect.sv - rising edge detector; FREQ_SYNC_EN adds a 2-flop input synchronizer
module freq_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise
);

    logic s;
    logic prev;

`ifdef FREQ_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], sig_i};
        end
    end

    assign s = sync[1];
`else
    assign s = sig_i;
`endif

    // prev runs in every state so a level already high at window open is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= s;
        end
    end

    assign rise = s & ~prev;

endmodule

// File: rtl/freq_gate_ctrl.sv
// rtl/freq_gate_ctrl.sv - gate window sequencer and edge counter with valid/ready result (FREQ_SYNC_EN optional)
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = FREQ_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             continuous_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             busy_o
);

    localparam int             GW        = $clog2(GATE_CYCLES + 1);
    localparam logic [GW-1:0]  GATE_LOAD = GW'(GATE_CYCLES - 1);

    freq_state_t      state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    freq_edge_detect u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig_i (sig_i),
        .rise  (rise)
    );

    // an edge arriving at full scale is dropped and flagged instead of wrapping
    always_comb begin
        cnt_next = edge_cnt;
        ovf_next = ovf;
        if (rise) begin
            if (edge_cnt == '1) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = edge_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        state    <= GATE;
                        gate_cnt <= GATE_LOAD;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                    end
                end
                GATE: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else begin
                        edge_cnt <= cnt_next;
                        ovf      <= ovf_next;
                        // last window cycle: its own edge is part of the result
                        if (gate_cnt == '0) begin
                            state   <= HOLD;
                            count_q <= cnt_next;
                            ovf_q   <= ovf_next;
                        end else begin
                            gate_cnt <= gate_cnt - 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else if (ready_i) begin
                        if (continuous_i) begin
                            state    <= GATE;
                            gate_cnt <= GATE_LOAD;
                            edge_cnt <= '0;
                            ovf      <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign valid_o    = (state == HOLD);
    assign busy_o     = (state == GATE) || (state == HOLD);
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule
